pri_icache_maint_fsm: RTL and testbench

- Per-core maintenance engine inside each private L1 instruction cache.
- Consumes the bypass, flush and selective-flush requests driven by the icache control unit over the private control bus, and returns the matching acks.
- Sequences the work on the L1 tag array: full-array invalidate walk, or single-line lookup-and-invalidate.
- Stalls the core fetch path while maintenance runs.

---
 rtl/pri_icache_maint_fsm.sv | 240 ++++++++++++++++++++++++
 tb/tb_pri_icache_maint_fsm.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pri_icache_maint_fsm.sv
// pri_icache_maint_fsm: L1 icache maintenance engine
// invalidate walks, selective line flush, bypass switching
module pri_icache_maint_fsm #(
  parameter int NB_WAYS     = 4,
  parameter int NB_SETS     = 32,
  parameter int LINE_OFFSET = 4,
  localparam int IDX_W      = $clog2(NB_SETS),
  localparam int TAG_W      = 32 - LINE_OFFSET - IDX_W,
  localparam int ENT_W      = TAG_W + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     bypass_req_i,
  output logic                     bypass_ack_o,
  input  logic                     flush_req_i,
  output logic                     flush_ack_o,
  input  logic                     sel_flush_req_i,
  input  logic [31:0]              sel_flush_addr_i,
  output logic                     sel_flush_ack_o,
  input  logic                     fetch_idle_i,
  output logic                     stall_fetch_o,
  output logic                     bypass_en_o,
  output logic                     busy_o,
  output logic                     tag_req_o,
  output logic                     tag_we_o,
  output logic [IDX_W-1:0]         tag_addr_o,
  output logic [NB_WAYS-1:0]       tag_way_we_o,
  output logic [ENT_W-1:0]         tag_wdata_o,
  input  logic [NB_WAYS*ENT_W-1:0] tag_rdata_i
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WAIT_IDLE,
    S_WALK,
    S_SEL_READ,
    S_SEL_CMP,
    S_SEL_WRITE,
    S_ACK
  } state_e;

  typedef enum logic [1:0] {
    OP_FLUSH,
    OP_SEL,
    OP_BYP_ON,
    OP_BYP_OFF
  } op_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NB_SETS - 1);

  state_e               r_state;
  op_e                  r_op;
  logic [IDX_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [TAG_W-1:0]     r_tag;
  logic                 r_stall;
  logic                 r_busy;
  logic                 r_byp;
  logic                 r_fack;
  logic                 r_sack;
  logic                 r_tag_req;
  logic                 r_tag_we;
  logic [IDX_W-1:0]     r_tag_addr;
  logic [NB_WAYS-1:0]   r_way_we;

  logic [NB_WAYS-1:0]   w_hit;
  logic                 w_walk_done;
  logic                 w_unused;

  assign w_walk_done = r_tag_req && (r_tag_addr == LAST);
  assign w_unused    = ^sel_flush_addr_i[LINE_OFFSET-1:0];

  // per-way hit: valid entry whose stored tag matches the captured tag
  always_comb begin
    w_hit = '0;
    for (int w = 0; w < NB_WAYS; w++) begin
      w_hit[w] = tag_rdata_i[w*ENT_W+TAG_W] &&
                 (tag_rdata_i[w*ENT_W +: TAG_W] == r_tag);
    end
  end

  // control FSM; every output is a register updated here
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_INIT;
      r_op       <= OP_FLUSH;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_stall    <= 1'b1;
      r_busy     <= 1'b1;
      r_byp      <= 1'b0;
      r_fack     <= 1'b0;
      r_sack     <= 1'b0;
      r_tag_req  <= 1'b0;
      r_tag_we   <= 1'b0;
      r_tag_addr <= '0;
      r_way_we   <= '0;
    end else begin
      r_fack    <= 1'b0;
      r_sack    <= 1'b0;
      r_tag_req <= 1'b0;
      r_tag_we  <= 1'b0;
      r_way_we  <= '0;
      unique case (r_state)
        S_INIT: begin
          if (w_walk_done) begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_tag_req  <= 1'b1;
            r_tag_we   <= 1'b1;
            r_way_we   <= '1;
            r_tag_addr <= r_cnt;
            r_cnt      <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (flush_req_i) begin
            r_op    <= OP_FLUSH;
            r_stall <= 1'b1;
            r_busy  <= 1'b1;
            if (r_byp) begin
              r_state <= S_ACK;
              r_fack  <= 1'b1;
            end else begin
              r_state <= S_WAIT_IDLE;
            end
          end else if (sel_flush_req_i) begin
            r_op    <= OP_SEL;
            r_idx   <= sel_flush_addr_i[LINE_OFFSET +: IDX_W];
            r_tag   <= sel_flush_addr_i[31 -: TAG_W];
            r_stall <= 1'b1;
            r_busy  <= 1'b1;
            if (r_byp) begin
              r_state <= S_ACK;
              r_sack  <= 1'b1;
            end else begin
              r_state <= S_WAIT_IDLE;
            end
          end else if (bypass_req_i != r_byp) begin
            r_op    <= bypass_req_i ? OP_BYP_ON : OP_BYP_OFF;
            r_state <= S_WAIT_IDLE;
            r_stall <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (fetch_idle_i) begin
            unique case (r_op)
              OP_FLUSH, OP_BYP_ON: begin
                r_state    <= S_WALK;
                r_tag_req  <= 1'b1;
                r_tag_we   <= 1'b1;
                r_way_we   <= '1;
                r_tag_addr <= r_cnt;
                r_cnt      <= r_cnt + 1'b1;
              end
              OP_BYP_OFF: begin
                r_state <= S_IDLE;
                r_byp   <= 1'b0;
                r_stall <= 1'b0;
                r_busy  <= 1'b0;
              end
              OP_SEL: begin
                r_state    <= S_SEL_READ;
                r_tag_req  <= 1'b1;
                r_tag_addr <= r_idx;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_WALK: begin
          if (w_walk_done) begin
            if (r_op == OP_FLUSH) begin
              r_state <= S_ACK;
              r_fack  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_byp   <= 1'b1;
              r_stall <= 1'b0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tag_req  <= 1'b1;
            r_tag_we   <= 1'b1;
            r_way_we   <= '1;
            r_tag_addr <= r_cnt;
            r_cnt      <= r_cnt + 1'b1;
          end
        end
        S_SEL_READ: begin
          r_state <= S_SEL_CMP;
        end
        S_SEL_CMP: begin
          if (|w_hit) begin
            r_state    <= S_SEL_WRITE;
            r_tag_req  <= 1'b1;
            r_tag_we   <= 1'b1;
            r_way_we   <= w_hit;
            r_tag_addr <= r_idx;
          end else begin
            r_state <= S_ACK;
            r_sack  <= 1'b1;
          end
        end
        S_SEL_WRITE: begin
          r_state <= S_ACK;
          r_sack  <= 1'b1;
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_INIT;
          r_stall <= 1'b1;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bypass_ack_o    = r_byp;
  assign bypass_en_o     = r_byp;
  assign flush_ack_o     = r_fack;
  assign sel_flush_ack_o = r_sack;
  assign stall_fetch_o   = r_stall;
  assign busy_o          = r_busy;
  assign tag_req_o       = r_tag_req;
  assign tag_we_o        = r_tag_we;
  assign tag_addr_o      = r_tag_addr;
  assign tag_way_we_o    = r_way_we;
  assign tag_wdata_o     = '0;

endmodule

// File: tb/tb_pri_icache_maint_fsm.sv
// tb_pri_icache_maint_fsm: randomized check of the maintenance
// engine against an event-timing and tag-contents model
module tb_pri_icache_maint_fsm;
  localparam int NW = 4;
  localparam int NS = 32;
  localparam int LO = 4;
  localparam int IW = 5;
  localparam int TW = 23;
  localparam int K_FL = 0;
  localparam int K_SEL = 1;
  localparam int K_BYP = 2;
  localparam int K_BOTH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic byp_req = 1'b0;
  logic fl_req = 1'b0;
  logic sel_req = 1'b0;
  logic fetch_idle = 1'b1;
  logic [31:0] sel_addr = '0;
  logic byp_ack, fl_ack, sel_ack, stall, bypass_en, busy;
  logic tag_req, tag_we;
  logic [IW-1:0] tag_addr;
  logic [NW-1:0] way_we;
  logic [TW:0] wdata;
  logic [NW*(TW+1)-1:0] rdata = '0;

  pri_icache_maint_fsm #(
    .NB_WAYS(NW), .NB_SETS(NS), .LINE_OFFSET(LO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .bypass_req_i(byp_req), .bypass_ack_o(byp_ack),
    .flush_req_i(fl_req), .flush_ack_o(fl_ack),
    .sel_flush_req_i(sel_req), .sel_flush_addr_i(sel_addr),
    .sel_flush_ack_o(sel_ack), .fetch_idle_i(fetch_idle),
    .stall_fetch_o(stall), .bypass_en_o(bypass_en),
    .busy_o(busy), .tag_req_o(tag_req), .tag_we_o(tag_we),
    .tag_addr_o(tag_addr), .tag_way_we_o(way_we),
    .tag_wdata_o(wdata), .tag_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tag array environment: 1-cycle read, masked write, refill preload
  logic mv [NS][NW];
  logic [TW-1:0] mt [NS][NW];
  logic pl_en = 1'b0;
  int pl_s = 0;
  int pl_w = 0;
  logic [TW-1:0] pl_t = '0;
  always @(posedge clk) begin
    if (pl_en) begin
      mv[pl_s][pl_w] <= 1'b1;
      mt[pl_s][pl_w] <= pl_t;
    end
    if (tag_req && tag_we)
      for (int w = 0; w < NW; w++)
        if (way_we[w]) begin
          mv[tag_addr][w] <= wdata[TW];
          mt[tag_addr][w] <= wdata[TW-1:0];
        end
    if (tag_req && !tag_we)
      for (int w = 0; w < NW; w++)
        rdata[w*(TW+1) +: TW+1] <= {mv[tag_addr][w], mt[tag_addr][w]};
  end

  // reference model state
  logic rv [NS][NW];
  logic [TW-1:0] rt [NS][NW];
  logic mbyp = 1'b0;
  logic [63:0] expq[$];
  logic [63:0] actq[$];
  logic [TW-1:0] pool [4] = '{23'h12345, 23'h12346, 23'h00abc, 23'h7fffff};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ev(int c, int code, int a, int m);
    return {32'(c), 8'(code), 16'(a), 8'(m)};
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        if (mv[s][w] !== rv[s][w] || (rv[s][w] && mt[s][w] !== rt[s][w]))
          n++;
    return n;
  endfunction

  task automatic clear_ref();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        rv[s][w] = 1'b0;
  endtask

  task automatic exp_walk(int start);
    for (int i = 0; i < NS; i++)
      expq.push_back(ev(start + i, 2, i, 15));
  endtask

  task automatic exp_sel(int t0, int dd, logic [31:0] a, output int done);
    int idx;
    logic [TW-1:0] tg;
    logic [NW-1:0] m;
    if (mbyp) done = t0 + 1;
    else begin
      idx = int'(a[LO +: IW]);
      tg = a[31 -: TW];
      m = '0;
      for (int w = 0; w < NW; w++)
        m[w] = rv[idx][w] && (rt[idx][w] == tg);
      expq.push_back(ev(t0 + 2 + dd, 1, idx, 0));
      if (m != 0) begin
        expq.push_back(ev(t0 + 4 + dd, 2, idx, int'(m)));
        done = t0 + 5 + dd;
        for (int w = 0; w < NW; w++)
          if (m[w]) rv[idx][w] = 1'b0;
      end else done = t0 + 4 + dd;
    end
    expq.push_back(ev(done, 4, 0, 0));
  endtask

  task automatic chk_rst(string tag);
    chk(tag, {stall, busy, bypass_en, byp_ack, tag_req,
              tag_we, fl_ack, sel_ack, way_we}, {8'b11000000, 4'b0});
  endtask

  task automatic preload(int s, int w, logic [TW-1:0] t);
    @(negedge clk);
    pl_en = 1'b1; pl_s = s; pl_w = w; pl_t = t;
    @(negedge clk);
    pl_en = 1'b0;
    rv[s][w] = 1'b1;
    rt[s][w] = t;
  endtask

  task automatic watch(int code, int rel, output int done_c);
    int fin;
    logic hit;
    fin = 0;
    done_c = -1;
    actq.delete();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cyc == rel) fetch_idle = 1'b1;
      if (tag_req)
        actq.push_back(ev(cyc, tag_we ? 2 : 1, int'(tag_addr),
                          tag_we ? int'(way_we) : 0));
      if (fl_ack) begin
        actq.push_back(ev(cyc, 3, 0, 0));
        fl_req = 1'b0;
      end
      if (sel_ack) begin
        actq.push_back(ev(cyc, 4, 0, 0));
        sel_req = 1'b0;
      end
      if (fin != 0) break;
      hit = (code == 3 && fl_ack) || (code == 4 && sel_ack) ||
            (code == 5 && bypass_en) || (code == 6 && !bypass_en);
      if (hit) begin
        done_c = cyc;
        fin = 1;
      end
    end
    fetch_idle = 1'b1;
  endtask

  task automatic check_run(string tag, int code, int rel, int edone);
    int dn;
    watch(code, rel, dn);
    chk({tag, "_done"}, dn, edone);
    chk({tag, "_nev"}, actq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < actq.size(); i++)
      chk({tag, "_ev"}, actq[i], expq[i]);
    chk({tag, "_idle"}, {stall, busy, bypass_en, byp_ack},
        {2'b00, mbyp, mbyp});
    chk({tag, "_mem"}, mem_diff(), 0);
  endtask

  task automatic run_op(string tag, int kind, int d, logic [31:0] a);
    int t, edone, code;
    expq.delete();
    edone = 0;
    code = 3;
    @(negedge clk);
    t = cyc;
    fetch_idle = (d == 0);
    case (kind)
      K_FL: fl_req = 1'b1;
      K_SEL: begin sel_req = 1'b1; sel_addr = a; end
      K_BYP: byp_req = ~byp_req;
      default: begin fl_req = 1'b1; sel_req = 1'b1; sel_addr = a; end
    endcase
    if (kind == K_FL || kind == K_BOTH) begin
      if (mbyp) edone = t + 1;
      else begin
        exp_walk(t + 2 + d);
        edone = t + 2 + d + NS;
        clear_ref();
      end
      expq.push_back(ev(edone, 3, 0, 0));
    end
    if (kind == K_SEL) begin
      exp_sel(t, d, a, edone);
      code = 4;
    end
    if (kind == K_BOTH) begin
      exp_sel(edone + 1, 0, a, edone);
      code = 4;
    end
    if (kind == K_BYP) begin
      if (!mbyp) begin
        exp_walk(t + 2 + d);
        edone = t + 2 + d + NS;
        clear_ref();
        code = 5;
      end else begin
        edone = t + 2 + d;
        code = 6;
      end
      mbyp = ~mbyp;
    end
    check_run(tag, code, (d > 0) ? t + d + 1 : -1, edone);
  endtask

  task automatic init_watch(string tag);
    int c0, nw, nack, fin;
    c0 = cyc;
    nw = 0;
    nack = 0;
    fin = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!stall) begin
        fin = cyc;
        break;
      end
      if (tag_req) begin
        chk({tag, "_wr"}, ev(cyc, tag_we ? 2 : 1, int'(tag_addr), int'(way_we)),
            ev(c0 + 1 + nw, 2, nw, 15));
        nw++;
      end
      if (fl_ack || sel_ack) nack++;
    end
    chk({tag, "_nwr"}, nw, NS);
    chk({tag, "_end"}, fin, c0 + 1 + NS);
    chk({tag, "_ack"}, nack, 0);
    clear_ref();
    mbyp = 1'b0;
    chk({tag, "_mem"}, mem_diff(), 0);
  endtask

  task automatic reset_mid_walk();
    int t;
    @(negedge clk);
    fl_req = 1'b1;
    fetch_idle = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tag_req && tag_we && tag_addr == 5'd10) break;
    end
    chk("mid_idx", {tag_req, tag_we, 3'b0, tag_addr}, {2'b11, 3'b0, 5'd10});
    rst_n = 1'b0;
    #1;
    chk_rst("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    init_watch("mid_init");
    t = cyc;
    expq.delete();
    exp_walk(t + 2);
    expq.push_back(ev(t + 2 + NS, 3, 0, 0));
    clear_ref();
    check_run("mid_fl", 3, -1, t + 2 + NS);
  endtask

  initial begin
    int kind, d, s;
    logic [TW-1:0] tg;
    clear_ref();
    repeat (3) @(negedge clk);
    chk_rst("rst");
    rst_n = 1'b1;
    init_watch("init");

    preload(7, 2, 23'h12345);
    run_op("sel_hit", K_SEL, 0, {23'h12345, 5'd7, 4'h0});
    preload(7, 2, 23'h12345);
    preload(7, 0, 23'h12345);
    run_op("sel_miss", K_SEL, 0, {23'h54321, 5'd7, 4'h0});
    run_op("sel_multi", K_SEL, 2, {23'h12345, 5'd7, 4'h0});
    run_op("fl", K_FL, 0, '0);
    run_op("fl_d5", K_FL, 5, '0);
    run_op("byp_on", K_BYP, 0, '0);
    run_op("byp_fl", K_FL, 0, '0);
    run_op("byp_sel", K_SEL, 0, {23'h12345, 5'd7, 4'h0});
    run_op("byp_off", K_BYP, 3, '0);
    preload(3, 1, 23'h00abc);
    run_op("both", K_BOTH, 0, {23'h00abc, 5'd3, 4'h0});
    reset_mid_walk();

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      d = $urandom_range(0, 4);
      s = $urandom_range(0, NS - 1);
      tg = pool[$urandom_range(0, 3)];
      repeat ($urandom_range(0, 3))
        preload(s, $urandom_range(0, NW - 1), pool[$urandom_range(0, 3)]);
      run_op("rnd", kind, d, {tg, 5'(s), 4'h0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
